despacho_saida: RTL and testbench
=================================

Name: despacho_saida

Overview:
- Write-side counterpart of the datapath's 6-way writeback select. That select gathers PC+1, IO, memory, ALU, immediate and file-table data into the register file; this block takes one register-file word and delivers it to a destination (IO output, data memory or file table).
- Sits after the register-file read port. It is driven by the control unit via a start pulse and a 3-bit destination code.
- Handles each sink's handshake, holds the datapath busy until delivery completes, and flags timeouts and illegal codes.

Parameters:
- TIMEOUT, 255: max cycles waiting for io_ack or tab_pronto before erro.
- MEM_LAT, 2: fixed cycles mem_escreve is held high per memory write (≥1).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- inicia  in  1  start request; sampled only when ocupado=0
- OpDestino  in  3  0 = discard, 1 = IO, 2 = memory, 3 = file table, 4..7 = illegal
- dado  in  32  word to deliver
- endereco  in  32  memory or file-table address
- ocupado  out  1  transfer in progress
- concluido  out  1  one-cycle pulse when the transfer ends (success or error)
- erro  out  1  one-cycle pulse coincident with concluido on timeout or illegal code
- io_dado  out  32  IO output word
- io_valido  out  1  IO request
- io_ack  in  1  IO accepted
- mem_escreve  out  1  memory write enable
- mem_endereco  out  32  memory address
- mem_dado  out  32  memory write data
- tab_escreve  out  1  file-table write request
- tab_endereco  out  32  file-table address
- tab_dado  out  32  file-table data
- tab_pronto  in  1  file table accepted

Behaviour:
- Reset (reset_n=0, asynchronous): state OCIOSO, all outputs 0, counters 0. Assertion mid-transfer aborts immediately: io_valido, mem_escreve and tab_escreve drop without waiting for the edge, and no concluido pulse is issued.
- Launch: in OCIOSO, inicia=1 at an edge latches dado, endereco and OpDestino into internal registers.
  - All sink data/address outputs come only from these registers, so inputs may change after launch.
  - ocupado=1 from the next cycle until the cycle after concluido.
  - inicia while ocupado=1 is ignored (no queueing).
- States:
  - OCIOSO: on inicia, next state is chosen by code: 0→FIM, 1→IO_ESPERA, 2→MEM_ESCRITA, 3→TAB_ESPERA, 4..7→FIM with error flag set.
  - IO_ESPERA: io_valido=1 with io_dado stable.
    - io_ack=1 at an edge → FIM; io_valido drops in the FIM cycle.
    - io_ack already high on entry completes after one io_valido cycle.
  - MEM_ESCRITA: mem_escreve=1 for exactly MEM_LAT cycles, then → FIM. There is no acknowledge.
  - TAB_ESPERA: tab_escreve=1 until tab_pronto=1 at an edge, then → FIM.
  - FIM: concluido=1 for one cycle, erro=1 if the error flag is set, then → OCIOSO with ocupado=0.
- Timeout:
  - In IO_ESPERA and TAB_ESPERA, the counter clears on state entry and increments each cycle.
  - When the count reaches TIMEOUT without an ack, go to FIM with the error flag set; the request drops in FIM.
  - An ack arriving on the same edge the counter hits TIMEOUT wins: success, no erro.
- Latency (inicia edge → concluido high):
  - discard: 2 cycles
  - illegal: 2 cycles
  - memory: MEM_LAT+2 cycles
  - IO / file table: k+2 cycles, where the ack is seen k cycles after entry (k ≥ 1).
- Only one sink request is ever high at a time; all request outputs are 0 in OCIOSO and FIM.
- Widths: the counter is wide enough for TIMEOUT (8 bits at default). Data and address paths are 32 bits, passed through unmodified.

Test Plan:
- Reset then idle → all outputs 0, ocupado=0. Pulse inicia with OpDestino=0, dado=0xDEADBEEF → concluido 2 cycles later, erro=0, no sink request ever high.
- OpDestino=1, dado=0x12345678, io_ack raised 3 cycles after io_valido → io_dado=0x12345678 held throughout, concluido 1 cycle after the ack edge, erro=0. Change dado during the wait → io_dado unchanged.
- OpDestino=2, endereco=0x40, dado=0xA5A5A5A5, MEM_LAT=2 → mem_escreve high exactly 2 cycles with addr/data stable, concluido at cycle 4 after inicia.
- OpDestino=3, tab_pronto never asserted, TIMEOUT=4 → tab_escreve high 4 cycles, then concluido=erro=1 for one cycle. Repeat with tab_pronto on the 4th cycle → erro=0.
- OpDestino=6 → concluido=erro=1 at cycle 2, no requests. inicia pulsed while ocupado=1 → ignored, exactly one concluido.
- reset_n dropped during IO_ESPERA → io_valido and ocupado go 0 asynchronously, no concluido. After release, a new transfer completes normally.

Source files
------------

// File: rtl/despacho_saida.sv
// Write-side dispatcher: delivers one register-file word to IO, data memory or the
// file table, handling each sink's handshake and flagging timeouts and illegal codes.
module despacho_saida #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inicia,
    input  logic [2:0]  OpDestino,
    input  logic [31:0] dado,
    input  logic [31:0] endereco,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro,
    output logic [31:0] io_dado,
    output logic        io_valido,
    input  logic        io_ack,
    output logic        mem_escreve,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_dado,
    output logic        tab_escreve,
    output logic [31:0] tab_endereco,
    output logic [31:0] tab_dado,
    input  logic        tab_pronto
);

    localparam int unsigned LIM = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
    localparam int unsigned CW  = $clog2(LIM + 1);
    localparam logic [CW-1:0] ESPERA_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MEM_MAX    = CW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        OCIOSO, LANCA, IO_ESPERA, MEM_ESCRITA, TAB_ESPERA, FIM
    } estado_t;

    estado_t       estado, estado_prox;
    logic [CW-1:0] cont, cont_prox;
    logic          falha, falha_prox;
    logic [2:0]    op_r;
    logic [31:0]   dado_r, end_r;

    logic ocupado_prox, concluido_prox, erro_prox;
    logic io_valido_prox, mem_escreve_prox, tab_escreve_prox;

    // Transfer payload is captured once at launch; sinks only ever see these copies.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_r   <= 3'd0;
            dado_r <= 32'd0;
            end_r  <= 32'd0;
        end else if (estado == OCIOSO && inicia) begin
            op_r   <= OpDestino;
            dado_r <= dado;
            end_r  <= endereco;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= OCIOSO;
            cont        <= '0;
            falha       <= 1'b0;
            ocupado     <= 1'b0;
            concluido   <= 1'b0;
            erro        <= 1'b0;
            io_valido   <= 1'b0;
            mem_escreve <= 1'b0;
            tab_escreve <= 1'b0;
        end else begin
            estado      <= estado_prox;
            cont        <= cont_prox;
            falha       <= falha_prox;
            ocupado     <= ocupado_prox;
            concluido   <= concluido_prox;
            erro        <= erro_prox;
            io_valido   <= io_valido_prox;
            mem_escreve <= mem_escreve_prox;
            tab_escreve <= tab_escreve_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        cont_prox   = cont;
        falha_prox  = falha;
        case (estado)
            OCIOSO: begin
                falha_prox = 1'b0;
                if (inicia) estado_prox = LANCA;
            end
            LANCA: begin
                cont_prox = '0;
                case (op_r)
                    3'd0:    estado_prox = FIM;
                    3'd1:    estado_prox = IO_ESPERA;
                    3'd2:    estado_prox = MEM_ESCRITA;
                    3'd3:    estado_prox = TAB_ESPERA;
                    default: begin
                        estado_prox = FIM;
                        falha_prox  = 1'b1;
                    end
                endcase
            end
            IO_ESPERA: begin
                // An ack on the timeout edge still counts as success.
                if (io_ack) begin
                    estado_prox = FIM;
                end else if (cont == ESPERA_MAX) begin
                    estado_prox = FIM;
                    falha_prox  = 1'b1;
                end else begin
                    cont_prox = cont + CW'(1);
                end
            end
            MEM_ESCRITA: begin
                if (cont == MEM_MAX) estado_prox = FIM;
                else                 cont_prox   = cont + CW'(1);
            end
            TAB_ESPERA: begin
                if (tab_pronto) begin
                    estado_prox = FIM;
                end else if (cont == ESPERA_MAX) begin
                    estado_prox = FIM;
                    falha_prox  = 1'b1;
                end else begin
                    cont_prox = cont + CW'(1);
                end
            end
            FIM: begin
                estado_prox = OCIOSO;
                falha_prox  = 1'b0;
            end
            default: estado_prox = OCIOSO;
        endcase

        // Outputs are registered from the next state so they line up with the state.
        ocupado_prox     = (estado_prox != OCIOSO);
        concluido_prox   = (estado_prox == FIM);
        erro_prox        = (estado_prox == FIM) && falha_prox;
        io_valido_prox   = (estado_prox == IO_ESPERA);
        mem_escreve_prox = (estado_prox == MEM_ESCRITA);
        tab_escreve_prox = (estado_prox == TAB_ESPERA);
    end

    assign io_dado      = dado_r;
    assign mem_endereco = end_r;
    assign mem_dado     = dado_r;
    assign tab_endereco = end_r;
    assign tab_dado     = dado_r;

endmodule

// File: tb/tb_despacho_saida.sv
// Directed bench for despacho_saida: cycle-by-cycle checks of each destination,
// timeout, illegal codes, ignored restarts and asynchronous abort.
module tb_despacho_saida;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        inicia;
    logic [2:0]  OpDestino;
    logic [31:0] dado, endereco;
    logic        ocupado, concluido, erro;
    logic [31:0] io_dado, mem_endereco, mem_dado, tab_endereco, tab_dado;
    logic        io_valido, io_ack, mem_escreve, tab_escreve, tab_pronto;

    int n_chk = 0;
    int n_ok  = 0;
    int n_concl = 0;
    int n_req   = 0;
    int n_multi = 0;

    despacho_saida #(.TIMEOUT(4), .MEM_LAT(2)) dut (
        .clock(clock), .reset_n(reset_n), .inicia(inicia), .OpDestino(OpDestino),
        .dado(dado), .endereco(endereco), .ocupado(ocupado), .concluido(concluido),
        .erro(erro), .io_dado(io_dado), .io_valido(io_valido), .io_ack(io_ack),
        .mem_escreve(mem_escreve), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
        .tab_escreve(tab_escreve), .tab_endereco(tab_endereco), .tab_dado(tab_dado),
        .tab_pronto(tab_pronto)
    );

    always #5 clock = ~clock;

    // Event tally sampled mid-cycle.
    always @(negedge clock) begin
        if (concluido) n_concl++;
        if (io_valido || mem_escreve || tab_escreve) n_req++;
        if ((int'(io_valido) + int'(mem_escreve) + int'(tab_escreve)) > 1) n_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_ok++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lanca(input logic [2:0] op, input logic [31:0] d, input logic [31:0] a);
        OpDestino = op;
        dado      = d;
        endereco  = a;
        inicia    = 1'b1;
        tick();
        inicia    = 1'b0;
    endtask

    // {ocupado, concluido, erro, io_valido, mem_escreve, tab_escreve}
    function automatic logic [31:0] flags();
        return {26'd0, ocupado, concluido, erro, io_valido, mem_escreve, tab_escreve};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, r0;
        reset_n = 1'b0; inicia = 1'b0; OpDestino = 3'd0; dado = '0; endereco = '0;
        io_ack = 1'b0; tab_pronto = 1'b0;
        tick(); tick();
        chk("reset_flags", flags(), 32'h00);
        chk("reset_io_dado", io_dado, 32'h0);
        chk("reset_mem_end", mem_endereco, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("idle_flags", flags(), 32'h00);

        // discard
        r0 = n_req;
        lanca(3'd0, 32'hDEADBEEF, 32'h0);
        chk("disc_c1", flags(), 32'h20);
        tick();
        chk("disc_c2_fim", flags(), 32'h30);
        tick();
        chk("disc_c3_idle", flags(), 32'h00);
        chk("disc_no_req", 32'(n_req - r0), 32'd0);

        // IO with ack after three valid cycles; input changes must not leak
        lanca(3'd1, 32'h12345678, 32'h0);
        chk("io_c1", flags(), 32'h20);
        tick();
        dado = 32'h0BADF00D;
        chk("io_c2", flags(), 32'h24);
        chk("io_dado_c2", io_dado, 32'h12345678);
        tick();
        chk("io_c3", flags(), 32'h24);
        tick();
        chk("io_c4", flags(), 32'h24);
        chk("io_dado_c4", io_dado, 32'h12345678);
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        chk("io_fim", flags(), 32'h30);
        tick();
        chk("io_idle", flags(), 32'h00);

        // IO with ack already high on entry
        io_ack = 1'b1;
        lanca(3'd1, 32'h55AA55AA, 32'h0);
        tick();
        chk("io_ack_entry_valid", flags(), 32'h24);
        tick();
        io_ack = 1'b0;
        chk("io_ack_entry_fim", flags(), 32'h30);
        tick();

        // memory write, MEM_LAT=2
        lanca(3'd2, 32'hA5A5A5A5, 32'h40);
        dado = 32'h11111111; endereco = 32'h99;
        chk("mem_c1", flags(), 32'h20);
        tick();
        chk("mem_c2", flags(), 32'h22);
        chk("mem_c2_end", mem_endereco, 32'h40);
        chk("mem_c2_dado", mem_dado, 32'hA5A5A5A5);
        tick();
        chk("mem_c3", flags(), 32'h22);
        chk("mem_c3_end", mem_endereco, 32'h40);
        tick();
        chk("mem_c4_fim", flags(), 32'h30);
        tick();
        chk("mem_idle", flags(), 32'h00);

        // file table timeout: four request cycles then error
        lanca(3'd3, 32'hCAFE0001, 32'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("tab_to_c%0d", i + 2), flags(), 32'h21);
        end
        chk("tab_to_end", tab_endereco, 32'h10);
        chk("tab_to_dado", tab_dado, 32'hCAFE0001);
        tick();
        chk("tab_to_fim", flags(), 32'h38);
        tick();
        chk("tab_to_idle", flags(), 32'h00);

        // file table ack on the timeout edge: success
        lanca(3'd3, 32'hCAFE0002, 32'h14);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("tab_ok_c%0d", i + 2), flags(), 32'h21);
        end
        tab_pronto = 1'b1;
        tick();
        tab_pronto = 1'b0;
        chk("tab_ok_fim", flags(), 32'h30);
        tick();

        // illegal code with a restart attempt while busy
        c0 = n_concl; r0 = n_req;
        lanca(3'd6, 32'h0, 32'h0);
        inicia = 1'b1; OpDestino = 3'd2;
        chk("ileg_c1", flags(), 32'h20);
        tick();
        inicia = 1'b0;
        chk("ileg_fim", flags(), 32'h38);
        tick(); tick(); tick();
        chk("ileg_idle", flags(), 32'h00);
        chk("ileg_one_concl", 32'(n_concl - c0), 32'd1);
        chk("ileg_no_req", 32'(n_req - r0), 32'd0);

        // asynchronous abort during IO wait
        lanca(3'd1, 32'h77777777, 32'h0);
        tick();
        chk("abort_pre", flags(), 32'h24);
        c0 = n_concl;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_async", flags(), 32'h00);
        tick(); tick();
        chk("abort_no_concl", 32'(n_concl - c0), 32'd0);
        reset_n = 1'b1;
        tick();

        // normal transfer after release
        lanca(3'd1, 32'h87654321, 32'h0);
        tick();
        chk("post_valid", flags(), 32'h24);
        chk("post_io_dado", io_dado, 32'h87654321);
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        chk("post_fim", flags(), 32'h30);
        tick();
        chk("post_idle", flags(), 32'h00);

        chk("one_hot_req", 32'(n_multi), 32'd0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
